sqrt_arbiter: RTL and testbench
===============================

SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 2..16.
REQ-002 Parameter WIDTH, default 16: radical width, range 2..32.
REQ-003 Derived constant QW = ceil(WIDTH/2): root width. Derived constant RW = QW+1: remainder width.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port aclr, input, 1: reset; synchronous, active-high.
REQ-006 Port ena, input, 1: clock enable for request acceptance and iteration.
REQ-007 Port req_valid, input, NREQ: per-requester request valid.
REQ-008 Port req_radical, input, NREQ*WIDTH: radicals; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port req_ready, output, NREQ: one-hot grant/accept strobe.
REQ-010 Port rsp_valid, output, 1: result valid.
REQ-011 Port rsp_ready, input, 1: result consumer ready.
REQ-012 Port rsp_id, output, clog2(NREQ): index of the requester that owns the result.
REQ-013 Port q, output, QW: floor(sqrt(radical)).
REQ-014 Port remainder, output, RW: radical - q*q.
REQ-015 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have three states, IDLE, CALC and DONE, with these transitions:
- IDLE->CALC on accept.
- CALC->DONE after QW enabled iterations.
- DONE->IDLE on rsp_valid&&rsp_ready.
REQ-017 Accept condition: state IDLE, ena=1, and at least one req_valid bit set.
- req_ready[g] SHALL be 1 in the accept cycle only; all other bits SHALL be 0.
- req_ready SHALL be combinational from state, ena, req_valid and the priority pointer.
REQ-018 Grant g SHALL be the first set req_valid bit, searching upward from pointer ptr and wrapping past NREQ-1 to 0.
- On accept, ptr SHALL become (g+1) mod NREQ.
REQ-019 On accept, the block SHALL latch the radical and g.
- An odd WIDTH radical is zero-extended by one MSB.
REQ-020 CALC SHALL perform one restoring bit-pair iteration per cycle with ena=1, MSB pair first.
- The partial remainder is RW+1 bits wide, so there is no overflow.
REQ-021 With ena=0 in CALC, the iteration count and all datapath registers SHALL hold.
REQ-022 Latency: accept at cycle T with ena held high gives rsp_valid=1 first at cycle T+QW+1.
REQ-023 In DONE, rsp_valid, rsp_id, q and remainder SHALL stay stable until rsp_ready=1, independent of ena.
REQ-024 rsp_valid SHALL be 0 outside DONE. q and remainder SHALL hold their last result outside DONE.
REQ-025 The response handshake cycle SHALL NOT also accept a request; the next accept is possible at the earliest one cycle later.
REQ-026 Requests arriving while busy SHALL see req_ready=0 and are not dropped; requesters hold req_valid.
REQ-027 A requester deasserting req_valid before grant SHALL simply not be considered.

Reset
REQ-028 aclr=1 at a clock edge SHALL force all of the following, regardless of ena or rsp_ready:
- state IDLE and ptr 0;
- iteration count, q and remainder 0;
- rsp_valid, rsp_id and busy 0.
REQ-029 While aclr=1, req_ready SHALL be 0.
REQ-030 Reset mid-CALC or mid-DONE SHALL discard the in-flight operation without producing a response.

Structure
REQ-031 Shared package sqrt_arb_pkg SHALL hold the FSM state enum and a clog2/width-derivation function.
REQ-032 One sub-module, sqrt_iter_core, SHALL hold the iterative datapath:
- ports: start, step, radical in; q and remainder out;
- it has no FSM of its own.
REQ-033 The round-robin arbiter and FSM SHALL reside in sqrt_arbiter.

Verification
REQ-034 WIDTH=16: req_valid[2] with radical 81 at cycle T -> req_ready[2] at T; rsp_valid at T+9; q=9, remainder=0, rsp_id=2.
REQ-035 Radical 65535 -> q=255, remainder=510. Radical 0 -> q=0, remainder=0. Radical 2 -> q=1, remainder=1.
REQ-036 All four req_valid held high, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0. Accepts are spaced QW+2=10 cycles apart.
REQ-037 rsp_ready low for 5 cycles in DONE -> outputs unchanged for those cycles; req_ready=0 throughout.
REQ-038 ena low for 3 cycles mid-CALC -> rsp_valid delayed exactly 3 cycles; result correct.
REQ-039 aclr pulsed at iteration 4, then request from requester 3 -> no response for the aborted operation; ptr restarts at 0, so requester 3 is granted.

Source files
------------

// File: rtl/sqrt_arb_pkg.sv
// Shared types and width helpers for the round-robin square-root arbiter.
package sqrt_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } arb_state_e;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  function automatic int unsigned root_width(input int unsigned w);
    return (w + 1) / 2;
  endfunction

endpackage

// File: rtl/sqrt_iter_core.sv
// Restoring square-root datapath: one radical bit pair per step, MSB pair first.
module sqrt_iter_core
  import sqrt_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned QW = root_width(WIDTH),
  localparam int unsigned RW = QW + 1
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] radical,
  output logic [QW-1:0]    q,
  output logic [RW-1:0]    remainder
);

  localparam int unsigned PW = 2 * QW;

  logic [PW-1:0] rad_q;
  logic [QW-1:0] root_q;
  logic [RW-1:0] rem_q;
  logic [RW+1:0] rem_shift;
  logic [RW+1:0] trial;
  logic          fits;

  // Extra headroom on the shifted remainder keeps the compare exact.
  always_comb begin
    rem_shift = {rem_q, rad_q[PW-1 -: 2]};
    trial     = {1'b0, root_q, 2'b01};
    fits      = rem_shift >= trial;
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      rad_q  <= '0;
      root_q <= '0;
      rem_q  <= '0;
    end else if (start) begin
      rad_q  <= PW'(radical);
      root_q <= '0;
      rem_q  <= '0;
    end else if (step) begin
      rad_q  <= rad_q << 2;
      root_q <= (root_q << 1) | QW'(fits);
      rem_q  <= fits ? RW'(rem_shift - trial) : RW'(rem_shift);
    end
  end

  assign q         = root_q;
  assign remainder = rem_q;

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter feeding a shared iterative square-root unit.
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned QW  = root_width(WIDTH),
  localparam int unsigned RW  = QW + 1,
  localparam int unsigned IDW = idx_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  ena,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_radical,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [QW-1:0]         q,
  output logic [RW-1:0]         remainder,
  output logic                  busy
);

  localparam int unsigned CW = idx_width(QW + 1);

  arb_state_e     state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] id_q;
  logic [CW-1:0]  cnt_q;
  logic [QW-1:0]  q_hold_q;
  logic [RW-1:0]  rem_hold_q;

  logic [IDW-1:0] grant;
  logic           accept;
  logic           step;
  logic [QW-1:0]  core_q;
  logic [RW-1:0]  core_rem;

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[IDW'(idx)]) begin
        grant = IDW'(idx);
        found = 1'b1;
      end
    end
  end

  assign accept = (state_q == StIdle) && ena && (|req_valid) && !aclr;
  assign step   = (state_q == StCalc) && ena;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  sqrt_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .aclr     (aclr),
    .start    (accept),
    .step     (step),
    .radical  (req_radical[grant*WIDTH +: WIDTH]),
    .q        (core_q),
    .remainder(core_rem)
  );

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      id_q       <= '0;
      cnt_q      <= '0;
      q_hold_q   <= '0;
      rem_hold_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StCalc;
            id_q    <= grant;
            cnt_q   <= '0;
            ptr_q   <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
          end
        end
        StCalc: begin
          if (ena) begin
            if (cnt_q == CW'(QW - 1)) begin
              state_q <= StDone;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        StDone: begin
          // Snapshot the result so it survives the core's next operation.
          if (rsp_ready) begin
            state_q    <= StIdle;
            q_hold_q   <= core_q;
            rem_hold_q <= core_rem;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign rsp_id    = id_q;
  assign q         = rsp_valid ? core_q : q_hold_q;
  assign remainder = rsp_valid ? core_rem : rem_hold_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter at NREQ=4, WIDTH=16.
module tb_sqrt_arbiter;

  logic        clk = 1'b0;
  logic        aclr;
  logic        ena;
  logic [3:0]  req_valid;
  logic [63:0] req_radical;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  q;
  logic [8:0]  remainder;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  sqrt_arbiter #(
    .NREQ (4),
    .WIDTH(16)
  ) dut (
    .clk        (clk),
    .aclr       (aclr),
    .ena        (ena),
    .req_valid  (req_valid),
    .req_radical(req_radical),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .q          (q),
    .remainder  (remainder),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits for rsp_valid; lat counts cycles after the accept cycle, -1 on timeout.
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic issue(input int who, input logic [15:0] rad, output logic [3:0] rdy,
                       output int lat);
    @(negedge clk);
    req_radical[who*16 +: 16] = rad;
    req_valid = 4'b0001 << who;
    ena = 1'b1;
    rsp_ready = 1'b0;
    #1;
    rdy = req_ready;
    wait_rsp(lat);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    aclr = 1'b1; ena = 1'b1; req_valid = 4'hf; rsp_ready = 1'b1; req_radical = '0;
    @(negedge clk); #1;
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    end
    @(negedge clk); #1;
    vectors++;
    if ({busy, rsp_valid, rsp_id, q, remainder} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b rsp_valid=%b id=%0d q=%0d rem=%0d want all 0",
               busy, rsp_valid, rsp_id, q, remainder);
    end
    aclr = 1'b0; req_valid = '0; rsp_ready = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] rdy;
    int lat;
    issue(2, 16'd81, rdy, lat);
    vectors++;
    if (rdy !== 4'b0100) begin miscompares++; $display("FAIL basic_grant: got %b want 0100", rdy); end
    vectors++;
    if (lat !== 9) begin miscompares++; $display("FAIL basic_latency: got %0d want 9", lat); end
    vectors++;
    if (rsp_id !== 2'd2 || q !== 8'd9 || remainder !== 9'd0) begin
      miscompares++;
      $display("FAIL basic_result: got id=%0d q=%0d rem=%0d want id=2 q=9 rem=0", rsp_id, q, remainder);
    end
    ack();
  endtask

  task automatic test_values();
    logic [15:0] rads [4] = '{16'd65535, 16'd0, 16'd2, 16'd1000};
    logic [7:0]  exp_q [4] = '{8'd255, 8'd0, 8'd1, 8'd31};
    logic [8:0]  exp_r [4] = '{9'd510, 9'd0, 9'd1, 9'd39};
    int          whos [4] = '{0, 3, 0, 1};
    logic [3:0]  rdy;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      issue(whos[i], rads[i], rdy, lat);
      vectors++;
      if (lat !== 9 || q !== exp_q[i] || remainder !== exp_r[i] || rsp_id !== 2'(whos[i])) begin
        miscompares++;
        $display("FAIL value_%0d: got lat=%0d id=%0d q=%0d rem=%0d want lat=9 id=%0d q=%0d rem=%0d",
                 rads[i], lat, rsp_id, q, remainder, whos[i], exp_q[i], exp_r[i]);
      end
      ack();
      if (i == 0) begin
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || q !== 8'd255 || remainder !== 9'd510) begin
          miscompares++;
          $display("FAIL idle_hold: got valid=%b q=%0d rem=%0d want valid=0 q=255 rem=510",
                   rsp_valid, q, remainder);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] exp_q [5] = '{8'd9, 8'd1, 8'd0, 8'd255, 8'd9};
    logic [3:0] acc_oh [5];
    int         acc_cyc [5];
    logic [1:0] rsp_seq [5];
    logic [7:0] rsp_q [5];
    int         nacc = 0;
    int         nrsp = 0;
    @(negedge clk); aclr = 1'b1;
    @(negedge clk); aclr = 1'b0;
    req_radical = {16'd65535, 16'd0, 16'd2, 16'd81};
    req_valid = 4'hf; rsp_ready = 1'b1; ena = 1'b1;
    for (int c = 0; c < 120 && nrsp < 5; c++) begin
      #1;
      if (req_ready !== 4'b0000 && nacc < 5) begin
        acc_oh[nacc] = req_ready; acc_cyc[nacc] = c; nacc++;
      end
      if (rsp_valid) begin
        rsp_seq[nrsp] = rsp_id; rsp_q[nrsp] = q; nrsp++;
      end
      @(negedge clk);
    end
    req_valid = '0; rsp_ready = 1'b0;
    vectors++;
    if (nacc !== 5 || nrsp !== 5) begin
      miscompares++; $display("FAIL rr_counts: got acc=%0d rsp=%0d want 5 and 5", nacc, nrsp);
    end else begin
      for (int k = 0; k < 5; k++) begin
        vectors++;
        if (acc_oh[k] !== exp_oh[k] || rsp_seq[k] !== 2'(k % 4) || rsp_q[k] !== exp_q[k]) begin
          miscompares++;
          $display("FAIL rr_%0d: got grant=%b id=%0d q=%0d want grant=%b id=%0d q=%0d",
                   k, acc_oh[k], rsp_seq[k], rsp_q[k], exp_oh[k], k % 4, exp_q[k]);
        end
        if (k > 0) begin
          vectors++;
          if (acc_cyc[k] - acc_cyc[k-1] !== 10) begin
            miscompares++;
            $display("FAIL rr_spacing_%0d: got %0d want 10", k, acc_cyc[k] - acc_cyc[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] rdy;
    int         lat;
    issue(1, 16'd30000, rdy, lat);
    vectors++;
    if (rdy !== 4'b0010 || lat !== 9) begin
      miscompares++; $display("FAIL bp_accept: got grant=%b lat=%0d want 0010 and 9", rdy, lat);
    end
    req_radical[63:48] = 16'd1000;
    req_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      ena = k[0];
      #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || q !== 8'd173 || remainder !== 9'd71 ||
          req_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got valid=%b id=%0d q=%0d rem=%0d rdy=%b want 1 1 173 71 0000",
                 k, rsp_valid, rsp_id, q, remainder, req_ready);
      end
      @(negedge clk);
    end
    ena = 1'b1; rsp_ready = 1'b1;
    #1;
    vectors++;
    if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL bp_handshake: got valid=%b rdy=%b want 1 and 0000", rsp_valid, req_ready);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || q !== 8'd173 || req_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL bp_next_accept: got valid=%b q=%0d rdy=%b want 0 173 1000",
               rsp_valid, q, req_ready);
    end
    wait_rsp(lat);
    vectors++;
    if (lat !== 9 || rsp_id !== 2'd3 || q !== 8'd31 || remainder !== 9'd39) begin
      miscompares++;
      $display("FAIL bp_second: got lat=%0d id=%0d q=%0d rem=%0d want 9 3 31 39",
               lat, rsp_id, q, remainder);
    end
    ack();
  endtask

  task automatic test_ena_stall();
    int lat = -1;
    @(negedge clk);
    req_radical[15:0] = 16'd65535; req_valid = 4'b0001; ena = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++; $display("FAIL stall_grant: got %b want 0001", req_ready);
    end
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      req_valid = '0;
      ena = !(n >= 4 && n <= 6);
      #1;
      if (rsp_valid) begin lat = n; break; end
    end
    ena = 1'b1;
    vectors++;
    if (lat !== 12 || q !== 8'd255 || remainder !== 9'd510) begin
      miscompares++;
      $display("FAIL stall_result: got lat=%0d q=%0d rem=%0d want 12 255 510", lat, q, remainder);
    end
    ack();
  endtask

  task automatic test_abort();
    int lat;
    bit seen = 1'b0;
    @(negedge clk);
    req_radical[31:16] = 16'd81; req_valid = 4'b0010; ena = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++; $display("FAIL abort_grant: got %b want 0010", req_ready);
    end
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk); req_valid = '0;
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    @(negedge clk);
    aclr = 1'b1; req_valid = 4'b1000; req_radical[63:48] = 16'd2;
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++; $display("FAIL abort_rdy_in_reset: got %b want 0000", req_ready);
    end
    @(negedge clk);
    aclr = 1'b0;
    #1;
    vectors++;
    if ({busy, rsp_valid, rsp_id, q, remainder} !== '0 || req_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL abort_cleared: busy=%b valid=%b id=%0d q=%0d rem=%0d rdy=%b want 0s and 1000",
               busy, rsp_valid, rsp_id, q, remainder, req_ready);
    end
    wait_rsp(lat);
    vectors++;
    if (seen || lat !== 9 || rsp_id !== 2'd3 || q !== 8'd1 || remainder !== 9'd1) begin
      miscompares++;
      $display("FAIL abort_after: got stale=%b lat=%0d id=%0d q=%0d rem=%0d want 0 9 3 1 1",
               seen, lat, rsp_id, q, remainder);
    end
    ack();
    // Pointer wrapped to 0 after granting 3, so requester 1 beats 3.
    @(negedge clk);
    req_valid = 4'b1010;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++; $display("FAIL wrap_grant: got %b want 0010", req_ready);
    end
    wait_rsp(lat);
    vectors++;
    if (lat !== 9 || rsp_id !== 2'd1 || q !== 8'd9) begin
      miscompares++;
      $display("FAIL wrap_result: got lat=%0d id=%0d q=%0d want 9 1 9", lat, rsp_id, q);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_round_robin();
    test_backpressure();
    test_ena_stall();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
